// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types and constants for the dCPU multi-cycle control sequencer.
package cpu_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        CtrlRst  = 3'd0,
        CtrlIf   = 3'd1,
        CtrlId   = 3'd2,
        CtrlEx   = 3'd3,
        CtrlMem  = 3'd4,
        CtrlWb   = 3'd5,
        CtrlHalt = 3'd6
    } ctrl_state_e;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    // Decoder flags captured in ID; the halt flag is acted on directly in ID and never stored.
    typedef struct packed {
        logic reg_we;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
    } dec_flags_t;

    // Cycles spent anywhere other than reset or halt count as active.
    function automatic logic is_active(ctrl_state_e s);
        return (s != CtrlRst) && (s != CtrlHalt);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_perf_counter.sv
// Free-running performance counter with synchronous active-low clear and increment enable.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Wraps modulo 2^CNT_W; no saturation.
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the dCPU core with perf counters and a
// data-memory watchdog that halts the core on a hung bus.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_ack,
    input  logic             dec_reg_we,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             dec_is_halt,
    input  logic             dec_is_branch,
    input  logic             dec_is_jump,
    input  logic             br_taken,
    input  logic             mem_ack,
    output logic             fetch_req,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    ctrl_state_e      state_q, state_d;
    dec_flags_t       flags_q;
    logic             taken_q;
    logic             timeout_err_q;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_hit;

    // Limit reached when this ack-less MEM cycle brings the wait count up to MEM_TIMEOUT.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (state_q == CtrlMem) && !mem_ack &&
                         ((32'(wait_q) + 32'd1) == MEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= CtrlRst;
            flags_q       <= '0;
            taken_q       <= 1'b0;
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == CtrlId) begin
                flags_q <= '{reg_we:    dec_reg_we,
                             is_load:   dec_is_load,
                             is_store:  dec_is_store,
                             is_branch: dec_is_branch,
                             is_jump:   dec_is_jump};
            end
            if (state_q == CtrlEx) begin
                taken_q <= flags_q.is_branch & br_taken;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        fetch_req = 1'b0;
        ir_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        halted    = 1'b0;
        unique case (state_q)
            CtrlRst: state_d = CtrlIf;
            CtrlIf: begin
                // IR is rewritten every IF cycle; the capture on the ack edge is the one that sticks.
                fetch_req = 1'b1;
                ir_we     = 1'b1;
                if (fetch_ack) state_d = CtrlId;
            end
            CtrlId: state_d = dec_is_halt ? CtrlHalt : CtrlEx;
            CtrlEx: state_d = (flags_q.is_load || flags_q.is_store) ? CtrlMem : CtrlWb;
            CtrlMem: begin
                mem_req = 1'b1;
                mem_we  = flags_q.is_store;
                if (mem_ack) begin
                    state_d = CtrlWb;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                    if (timeout_hit) state_d = CtrlHalt;
                end
            end
            CtrlWb: begin
                rf_we   = flags_q.reg_we & ~flags_q.is_store;
                pc_we   = 1'b1;
                pc_sel  = flags_q.is_jump | (flags_q.is_branch & taken_q);
                state_d = CtrlIf;
            end
            CtrlHalt: halted = 1'b1;
            default:  state_d = CtrlRst;
        endcase
    end

    assign timeout_err = timeout_err_q;

    perf_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_cnt (
        .clk_i  (clk),
        .clr_ni (rst_n),
        .en_i   (is_active(state_q)),
        .count_o(cycle_cnt)
    );

    perf_counter #(
        .CNT_W(CNT_W)
    ) u_instret (
        .clk_i  (clk),
        .clr_ni (rst_n),
        .en_i   (state_q == CtrlWb),
        .count_o(instret)
    );

endmodule
